// File: rtl/fp_convert_pipe_if.sv
// Handshake bundle for fp_convert_pipe: operand issue side (in_*) and writeback side (out_*).
// slave is the conversion unit's view; master is the upstream/downstream environment's view.
interface fp_convert_pipe_if #(
   parameter int TAG_W = 8
) ();
   logic             in_valid;
   logic             in_ready;
   logic             in_op;
   logic [31:0]      in_data;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_data;
   logic [TAG_W-1:0] out_tag;
   logic [2:0]       out_flags;

   modport slave (
      input  in_valid, in_op, in_data, in_tag, out_ready,
      output in_ready, out_valid, out_data, out_tag, out_flags
   );

   modport master (
      output in_valid, in_op, in_data, in_tag, out_ready,
      input  in_ready, out_valid, out_data, out_tag, out_flags
   );
endinterface

// File: rtl/fp_convert_pipe.sv
// F2I (truncating, saturating) / I2F (round-nearest-even) converter; 2-cycle latency, one op per cycle.
// Backpressure: each stage advances when empty or when the stage after it drains; in_ready is combinational.
module fp_convert_pipe #(
   parameter int TAG_W = 8
) (
   input  logic clk,
   input  logic rst_n,
   fp_convert_pipe_if.slave io
);

   typedef struct packed {
      logic             op;
      logic             sign;
      logic [30:0]      val;     // F2I: integer magnitude; I2F: normalised bits below the hidden one
      logic [4:0]       clz;
      logic             zero;
      logic             sat;
      logic             nan;
      logic             min;
      logic             inexact;
      logic [TAG_W-1:0] tag;
   } s1_t;

   function automatic logic [4:0] clz32(input logic [31:0] v);
      clz32 = 5'd31;
      for (int i = 0; i < 32; i++) begin
         if (v[i]) clz32 = 5'(31 - i);
      end
   endfunction

   logic s1_vld, s2_vld;
   logic s1_adv, s2_adv;
   s1_t  s1, s1_nxt;

   logic [31:0]      out_data_q;
   logic [TAG_W-1:0] out_tag_q;
   logic [2:0]       out_flags_q;

   assign s2_adv      = !s2_vld || io.out_ready;
   assign s1_adv      = !s1_vld || s2_adv;
   assign io.in_ready = s1_adv;

   // ---------------- S1: decode, classify, CLZ, align ----------------
   logic [7:0]  f_exp;
   logic [23:0] f_man;
   logic [7:0]  f_rsh;
   logic [55:0] f_aln;
   logic        f_nan, f_min, f_sat, f_small;
   logic [31:0] i_mag;
   logic [4:0]  i_clz;
   logic [30:0] i_norm;

   assign f_exp   = io.in_data[30:23];
   assign f_man   = {1'b1, io.in_data[22:0]};
   // Integer part lands in f_aln[55:25]; the 32 pad bits guarantee nothing falls off the bottom.
   assign f_rsh   = 8'd157 - f_exp;
   assign f_aln   = {f_man, 32'd0} >> f_rsh;
   assign f_nan   = (f_exp == 8'hFF) && (io.in_data[22:0] != 23'd0);
   assign f_min   = (io.in_data == 32'hCF00_0000);
   assign f_sat   = (f_exp >= 8'd158);
   assign f_small = (f_exp < 8'd127);

   assign i_mag   = io.in_data[31] ? (~io.in_data + 32'd1) : io.in_data;
   assign i_clz   = clz32(i_mag);
   assign i_norm  = 31'(i_mag << i_clz);

   always_comb begin
      s1_nxt      = '0;
      s1_nxt.op   = io.in_op;
      s1_nxt.sign = io.in_data[31];
      s1_nxt.tag  = io.in_tag;
      if (io.in_op) begin
         s1_nxt.val  = i_norm;
         s1_nxt.clz  = i_clz;
         s1_nxt.zero = (io.in_data == 32'd0);
      end else begin
         s1_nxt.val     = f_aln[55:25];
         s1_nxt.zero    = f_small;
         s1_nxt.sat     = f_sat;
         s1_nxt.nan     = f_nan;
         s1_nxt.min     = f_min;
         s1_nxt.inexact = f_small ? (|io.in_data[30:0]) : (|f_aln[24:0]);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_vld <= 1'b0;
      end else if (s1_adv) begin
         s1_vld <= io.in_valid;
         if (io.in_valid) s1 <= s1_nxt;
      end
   end

   // ---------------- S2: round, saturate, pack, flags ----------------
   logic        i_g, i_st, i_up;
   logic [23:0] i_rnd;
   logic [7:0]  i_exp;
   logic [31:0] f_mag;
   logic [31:0] s2_dat;
   logic [2:0]  s2_flg;

   assign i_g   = s1.val[7];
   assign i_st  = |s1.val[6:0];
   assign i_up  = i_g && (i_st || s1.val[8]);
   // A carry out of the mantissa leaves i_rnd[22:0] at zero and bumps the exponent.
   assign i_rnd = {1'b0, s1.val[30:8]} + 24'(i_up);
   assign i_exp = 8'd158 - {3'b000, s1.clz} + 8'(i_rnd[23]);
   assign f_mag = {1'b0, s1.val};

   always_comb begin
      s2_dat = '0;
      s2_flg = '0;
      if (s1.op) begin
         if (!s1.zero) begin
            s2_dat = {s1.sign, i_exp, i_rnd[22:0]};
            s2_flg = {2'b00, i_g || i_st};
         end
      end else if (s1.nan) begin
         s2_dat = 32'h7FFF_FFFF;
         s2_flg = 3'b100;
      end else if (s1.min) begin
         s2_dat = 32'h8000_0000;
      end else if (s1.sat) begin
         s2_dat = s1.sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
         s2_flg = 3'b010;
      end else begin
         s2_dat = s1.zero ? 32'd0 : (s1.sign ? (~f_mag + 32'd1) : f_mag);
         s2_flg = {2'b00, s1.inexact};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s2_vld      <= 1'b0;
         out_data_q  <= '0;
         out_tag_q   <= '0;
         out_flags_q <= '0;
      end else if (s2_adv) begin
         s2_vld <= s1_vld;
         if (s1_vld) begin
            out_data_q  <= s2_dat;
            out_tag_q   <= s1.tag;
            out_flags_q <= s2_flg;
         end
      end
   end

   assign io.out_valid = s2_vld;
   assign io.out_data  = out_data_q;
   assign io.out_tag   = out_tag_q;
   assign io.out_flags = out_flags_q;

endmodule

// File: tb/tb_fp_convert_pipe.sv
// Directed-vector bench for fp_convert_pipe: conversion table, backpressure stream, mid-flight reset.
module tb_fp_convert_pipe;

   localparam int NV = 21;

   typedef struct packed {
      logic        op;
      logic [31:0] din;
      logic [31:0] dout;
      logic [2:0]  flags;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   fp_convert_pipe_if #(.TAG_W(8)) ifc ();
   fp_convert_pipe #(.TAG_W(8)) dut (.clk(clk), .rst_n(rst_n), .io(ifc));

   vec_t vecs [NV];
   int   n_chk  = 0;
   int   n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int   sent, recv, occ;
      logic stalled, in_x, out_x, seen;
      logic [31:0] hd;
      logic [7:0]  ht;
      logic [2:0]  hf;

      vecs[0]  = '{1'b0, 32'h41200000, 32'h0000000A, 3'b000};
      vecs[1]  = '{1'b0, 32'hC0600000, 32'hFFFFFFFD, 3'b001};
      vecs[2]  = '{1'b0, 32'h4F000000, 32'h7FFFFFFF, 3'b010};
      vecs[3]  = '{1'b0, 32'h7FC00000, 32'h7FFFFFFF, 3'b100};
      vecs[4]  = '{1'b0, 32'hCF000000, 32'h80000000, 3'b000};
      vecs[5]  = '{1'b1, 32'h0000000A, 32'h41200000, 3'b000};
      vecs[6]  = '{1'b1, 32'h01000001, 32'h4B800000, 3'b001};
      vecs[7]  = '{1'b1, 32'h01000003, 32'h4B800002, 3'b001};
      vecs[8]  = '{1'b1, 32'h7FFFFFFF, 32'h4F000000, 3'b001};
      vecs[9]  = '{1'b1, 32'h80000000, 32'hCF000000, 3'b000};
      vecs[10] = '{1'b0, 32'hFF800000, 32'h80000000, 3'b010};
      vecs[11] = '{1'b0, 32'h7F800000, 32'h7FFFFFFF, 3'b010};
      vecs[12] = '{1'b0, 32'h3F000000, 32'h00000000, 3'b001};
      vecs[13] = '{1'b0, 32'h80000000, 32'h00000000, 3'b000};
      vecs[14] = '{1'b0, 32'h4E800000, 32'h40000000, 3'b000};
      vecs[15] = '{1'b0, 32'hCF000001, 32'h80000000, 3'b010};
      vecs[16] = '{1'b1, 32'hFFFFFFFF, 32'hBF800000, 3'b000};
      vecs[17] = '{1'b1, 32'h00000000, 32'h00000000, 3'b000};
      vecs[18] = '{1'b0, 32'h3FC00000, 32'h00000001, 3'b001};
      vecs[19] = '{1'b1, 32'h01000002, 32'h4B800001, 3'b000};
      vecs[20] = '{1'b1, 32'h01000005, 32'h4B800002, 3'b001};

      rst_n         = 1'b0;
      ifc.in_valid  = 1'b0;
      ifc.in_op     = 1'b0;
      ifc.in_data   = '0;
      ifc.in_tag    = '0;
      ifc.out_ready = 1'b1;

      // Reset state
      repeat (3) tick();
      chk("rst_out_valid", 32'(ifc.out_valid), 32'd0);
      chk("rst_out_data",  ifc.out_data,       32'd0);
      chk("rst_out_tag",   32'(ifc.out_tag),   32'd0);
      chk("rst_out_flags", 32'(ifc.out_flags), 32'd0);
      rst_n = 1'b1;
      tick();
      chk("rst_in_ready", 32'(ifc.in_ready), 32'd1);

      // Table: op presented after edge k, transferred at k+1, visible after k+2
      for (int i = 0; i < NV; i++) begin
         ifc.in_valid = 1'b1;
         ifc.in_op    = vecs[i].op;
         ifc.in_data  = vecs[i].din;
         ifc.in_tag   = 8'(i + 16);
         tick();
         ifc.in_valid = 1'b0;
         chk($sformatf("v%0d_early", i), 32'(ifc.out_valid), 32'd0);
         tick();
         chk($sformatf("v%0d_valid", i), 32'(ifc.out_valid), 32'd1);
         chk($sformatf("v%0d_data", i),  ifc.out_data,       vecs[i].dout);
         chk($sformatf("v%0d_flags", i), 32'(ifc.out_flags), 32'(vecs[i].flags));
         chk($sformatf("v%0d_tag", i),   32'(ifc.out_tag),   32'(i + 16));
      end
      tick();

      // Backpressure stream: 8 tagged ops, random out_ready
      sent = 0; recv = 0; occ = 0; stalled = 1'b0;
      hd = '0; ht = '0; hf = '0;
      for (int cyc = 0; cyc < 300 && recv < 8; cyc++) begin
         if (stalled) begin
            chk("bp_hold_valid", 32'(ifc.out_valid), 32'd1);
            chk("bp_hold_data",  ifc.out_data,       hd);
            chk("bp_hold_tag",   32'(ifc.out_tag),   32'(ht));
            chk("bp_hold_flags", 32'(ifc.out_flags), 32'(hf));
         end
         ifc.out_ready = (cyc < 4) ? 1'b0 : 1'($urandom_range(0, 1));
         ifc.in_valid  = (sent < 8);
         if (sent < 8) begin
            ifc.in_op   = vecs[sent].op;
            ifc.in_data = vecs[sent].din;
            ifc.in_tag  = 8'(sent);
         end
         #1;
         chk("bp_in_ready", 32'(ifc.in_ready), 32'((occ < 2) || ifc.out_ready));
         in_x  = ifc.in_valid && ifc.in_ready;
         out_x = ifc.out_valid && ifc.out_ready;
         if (out_x) begin
            if (recv < 8) begin
               chk($sformatf("bp%0d_data", recv),  ifc.out_data,       vecs[recv].dout);
               chk($sformatf("bp%0d_flags", recv), 32'(ifc.out_flags), 32'(vecs[recv].flags));
            end
            chk($sformatf("bp%0d_tag", recv), 32'(ifc.out_tag), 32'(recv));
            recv++;
         end
         stalled = ifc.out_valid && !ifc.out_ready;
         hd = ifc.out_data;
         ht = ifc.out_tag;
         hf = ifc.out_flags;
         occ = occ + int'(in_x) - int'(out_x);
         if (in_x) sent++;
         @(posedge clk);
         #1;
      end
      ifc.in_valid = 1'b0;
      chk("bp_recv_count", 32'(recv), 32'd8);
      ifc.out_ready = 1'b1;
      repeat (3) tick();

      // Reset mid-flight: two ops held in the pipe, nothing drained
      ifc.out_ready = 1'b0;
      ifc.in_valid  = 1'b1;
      ifc.in_op     = vecs[0].op;
      ifc.in_data   = vecs[0].din;
      ifc.in_tag    = 8'hA0;
      tick();
      ifc.in_op     = vecs[1].op;
      ifc.in_data   = vecs[1].din;
      ifc.in_tag    = 8'hA1;
      tick();
      ifc.in_valid = 1'b0;
      chk("mr_pre_in_ready", 32'(ifc.in_ready), 32'd0);
      rst_n = 1'b0;
      tick();
      chk("mr_out_valid", 32'(ifc.out_valid), 32'd0);
      chk("mr_out_data",  ifc.out_data,       32'd0);
      chk("mr_out_tag",   32'(ifc.out_tag),   32'd0);
      rst_n = 1'b1;
      ifc.out_ready = 1'b1;
      #1;
      chk("mr_in_ready", 32'(ifc.in_ready), 32'd1);
      seen = 1'b0;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (ifc.out_valid) seen = 1'b1;
      end
      chk("mr_no_ghost", 32'(seen), 32'd0);

      ifc.in_valid = 1'b1;
      ifc.in_op    = vecs[7].op;
      ifc.in_data  = vecs[7].din;
      ifc.in_tag   = 8'hB7;
      tick();
      ifc.in_valid = 1'b0;
      chk("post_early", 32'(ifc.out_valid), 32'd0);
      tick();
      chk("post_valid", 32'(ifc.out_valid), 32'd1);
      chk("post_data",  ifc.out_data,       vecs[7].dout);
      chk("post_flags", 32'(ifc.out_flags), 32'(vecs[7].flags));
      chk("post_tag",   32'(ifc.out_tag),   32'hB7);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/fp_convert_pipe.md
# fp_convert_pipe

Two-stage pipelined float/integer conversion unit for the compute arithmetic cluster. It converts IEEE-754 single-precision values to signed 32-bit integers and back. It replaces the bare combinational converters on the ALU path with a valid/ready-handshaked, full-throughput pipeline that adds correct rounding, saturation and exception flags. It sits between operand issue (upstream) and ALU result writeback (downstream), and carries an opaque tag for writeback routing.

## Interface
- TAG_W, 8, width of the opaque tag passed through alongside each operation
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  upstream presents an operation
- in_ready  out  1  unit accepts the operation this cycle
- in_op  in  1  0 = F2I (float to int32), 1 = I2F (int32 to float)
- in_data  in  32  operand (float bits for F2I, two's-complement int for I2F)
- in_tag  in  TAG_W  passed through unchanged
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts result
- out_data  out  32  result bits
- out_tag  out  TAG_W  tag of the result
- out_flags  out  3  {invalid, overflow, inexact}

## Operation
- Pipeline registers:
  - S1: decode, classify, count leading zeros, align shift.
  - S2: round, saturate, pack, flags.
- Each stage holds a valid bit. There is no other state machine.
- Per-stage state is EMPTY or FULL:
  - EMPTY→FULL on load.
  - FULL→EMPTY when the stage drains with no new load.
  - FULL→FULL on simultaneous drain and load.
- F2I: truncates toward zero.
  - Exponent < 127 (including zero and denormals) → 0. inexact = 1 if any exponent/mantissa bit is nonzero.
  - Exponent 127..157 → shifted magnitude, negated if sign = 1. inexact = 1 if any fraction bit is shifted out.
  - Exponent ≥ 158, or +Inf → 0x7FFFFFFF with overflow. Negative values → 0x80000000 with overflow.
  - Exception to the above: exactly 0xCF000000 (−2^31) → 0x80000000 with no flags.
  - NaN (exponent 255, mantissa ≠ 0) → 0x7FFFFFFF with invalid only.
- I2F: round to nearest, ties to even.
  - 0 → 0x00000000.
  - Otherwise take the magnitude of the two's complement and compute CLZ.
  - Exponent = 127 + 31 − CLZ.
  - Normalised bits [30:8] form the mantissa; guard = bit 7, sticky = OR of bits [6:0].
  - Increment the mantissa when guard & (sticky | mantissa lsb).
  - A mantissa carry-out increments the exponent and clears the mantissa.
  - inexact = guard | sticky. I2F never sets invalid or overflow.
  - 0x80000000 → 0xCF000000 exactly, no flags.
- Flags are only meaningful when out_valid = 1.

## Timing
- Reset (rst_n = 0 at a rising edge) forces S1/S2 valid = 0 and out_valid = 0.
- During reset, out_data, out_tag and out_flags = 0. in_ready = 1 from the first cycle after reset deasserts.
- Reset mid-operation discards all in-flight results; no partial output appears.
- Transfers:
  - Input transfer when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
- Latency: an operation accepted at edge N is presented with out_valid = 1 after edge N+2, provided no stall occurs.
- Throughput: one operation per cycle while out_ready = 1.
- Backpressure:
  - S2 advances when !S2.valid | out_ready.
  - S1 advances when !S1.valid | S2 advancing.
  - in_ready equals the S1 advance condition (combinational from out_ready, no bubble).
- While stalled, out_data, out_tag and out_flags hold stable. Stalls never drop or duplicate operations.
- in_* values are don't-care when in_valid = 0. Output fields are registered.

## Test plan
- F2I basic: in_op=0, in_data=0x41200000 (10.0) → out_data=0x0000000A, flags=000.
- F2I with truncation: 0xC0600000 (−3.5) → 0xFFFFFFFD, inexact.
- F2I saturation:
  - 0x4F000000 (2^31) → 0x7FFFFFFF, overflow.
  - 0x7FC00000 (NaN) → 0x7FFFFFFF, invalid.
  - 0xCF000000 → 0x80000000, flags=000.
- I2F rounding:
  - 0x0000000A → 0x41200000.
  - 0x01000001 → 0x4B800000, inexact.
  - 0x01000003 → 0x4B800002, inexact.
  - 0x7FFFFFFF → 0x4F000000, inexact.
  - 0x80000000 → 0xCF000000, no flags.
- Backpressure: stream 8 tagged ops (tags 0..7) with out_ready toggling pseudo-randomly → results appear in order with matching tags. Outputs stay stable while out_ready = 0, and in_ready = 0 whenever both stages are full and out_ready = 0.
- Reset mid-flight: accept 2 ops, then assert rst_n = 0 for one edge → out_valid = 0 the next cycle, and neither op ever emerges. A new op issued after reset returns with 2-cycle latency.
